// File: rtl/mac_engine_datapath.sv
// Streaming multiply-accumulate datapath: joint a/b(/c) intake, a multiply stage,
// then an accumulate/output stage feeding a registered d stream.
module mac_engine_datapath #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [31:0]          a_data_i,
    input  logic [3:0]           a_strb_i,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    input  logic [31:0]          b_data_i,
    input  logic [3:0]           b_strb_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [31:0]          c_data_i,
    input  logic [3:0]           c_strb_i,
    input  logic                 c_valid_i,
    output logic                 c_ready_o,
    output logic [31:0]          d_data_o,
    output logic [3:0]           d_strb_o,
    output logic                 d_valid_o,
    input  logic                 d_ready_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    input  logic [4:0]           shift_i,
    input  logic                 simple_mul_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [4:0]           shift_q, shift_d;
    logic                 simple_q, simple_d;
    logic                 done_q, done_d;
    logic                 s1_valid_q, s1_valid_d, first_q, first_d, last_q, last_d;
    logic signed [63:0]   prod_q, prod_d, c_sext_q, c_sext_d, acc_q, acc_d;
    logic                 d_valid_q, d_valid_d, d_last_q, d_last_d;
    logic [31:0]          d_data_q, d_data_d;

    logic                 need_c, s2_adv, fire, d_hs;
    logic signed [63:0]   a_ext, b_ext, acc_new;
    logic                 strb_unused;

    // A transfer happens on a rising edge where valid and ready are both high;
    // a source never drops valid or changes data before that edge.
    assign need_c  = !simple_q && (cnt_q == '0);
    assign s2_adv  = enable_i && s1_valid_q && (!d_valid_q || d_ready_i);
    assign fire    = enable_i && (state_q == RUN) && (cnt_q < len_q)
                     && (!s1_valid_q || s2_adv) && a_valid_i && b_valid_i
                     && (!need_c || c_valid_i);
    assign d_hs    = enable_i && d_valid_q && d_ready_i;

    assign a_ext   = {{32{a_data_i[31]}}, a_data_i};
    assign b_ext   = {{32{b_data_i[31]}}, b_data_i};
    assign acc_new = (first_q ? c_sext_q : acc_q) + prod_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        shift_d    = shift_q;
        simple_d   = simple_q;
        cnt_d      = cnt_q;
        done_d     = enable_i ? 1'b0 : done_q;
        s1_valid_d = s1_valid_q;
        prod_d     = prod_q;
        c_sext_d   = c_sext_q;
        first_d    = first_q;
        last_d     = last_q;
        acc_d      = acc_q;
        d_valid_d  = d_valid_q;
        d_data_d   = d_data_q;
        d_last_d   = d_last_q;
        if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            state_d  = RUN;
                            len_d    = len_i;
                            shift_d  = shift_i;
                            simple_d = simple_mul_i;
                            cnt_d    = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (d_hs && d_last_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (d_hs) d_valid_d = 1'b0;
            if (s2_adv) begin
                s1_valid_d = 1'b0;
                if (simple_q) begin
                    d_valid_d = 1'b1;
                    d_data_d  = 32'(prod_q >>> shift_q);
                    d_last_d  = last_q;
                end else begin
                    acc_d = acc_new;
                    if (last_q) begin
                        d_valid_d = 1'b1;
                        d_data_d  = 32'(acc_new >>> shift_q);
                        d_last_d  = 1'b1;
                    end
                end
            end

            if (fire) begin
                s1_valid_d = 1'b1;
                prod_d     = a_ext * b_ext;
                c_sext_d   = {{32{c_data_i[31]}}, c_data_i};
                first_d    = (cnt_q == '0);
                last_d     = (cnt_q == len_q - CNT_WIDTH'(1));
                cnt_d      = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            shift_q    <= '0;
            simple_q   <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            prod_q     <= '0;
            c_sext_q   <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            d_valid_q  <= 1'b0;
            d_data_q   <= '0;
            d_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            simple_q   <= simple_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
            c_sext_q   <= c_sext_d;
            first_q    <= first_d;
            last_q     <= last_d;
            acc_q      <= acc_d;
            d_valid_q  <= d_valid_d;
            d_data_q   <= d_data_d;
            d_last_q   <= d_last_d;
        end
    end

    // Input byte strobes carry no meaning for this datapath.
    assign strb_unused = ^{a_strb_i, b_strb_i, c_strb_i};

    assign a_ready_o   = fire;
    assign b_ready_o   = fire;
    assign c_ready_o   = fire && need_c;
    assign d_data_o    = d_data_q;
    assign d_strb_o    = 4'hF;
    assign d_valid_o   = d_valid_q;
    assign busy_o      = (state_q == RUN);
    assign done_o      = done_q;
    assign cnt_o       = cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mac_engine_datapath.sv
// Directed bench for mac_engine_datapath: stimulus pushes expected d values into
// a queue, a negedge monitor pops and compares on every d handshake.
module tb_mac_engine_datapath;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_i, enable_i, clear_i;
    logic [31:0]   a_data_i, b_data_i, c_data_i, d_data_o;
    logic [3:0]    a_strb_i, b_strb_i, c_strb_i, d_strb_o;
    logic          a_valid_i, b_valid_i, c_valid_i, d_ready_i;
    logic          a_ready_o, b_ready_o, c_ready_o, d_valid_o;
    logic          start_i, simple_mul_i, busy_o, done_o, dbg_state_o;
    logic [CW-1:0] len_i, cnt_o;
    logic [4:0]    shift_i;

    int            tests_run = 0;
    int            tests_failed = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   va[$], vb[$];
    int            c_ready_cnt = 0;
    int            ab_ready_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [31:0]   prev_data = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mac_engine_datapath #(.CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .a_data_i(a_data_i), .a_strb_i(a_strb_i), .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
        .b_data_i(b_data_i), .b_strb_i(b_strb_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .c_data_i(c_data_i), .c_strb_i(c_strb_i), .c_valid_i(c_valid_i), .c_ready_o(c_ready_o),
        .d_data_o(d_data_o), .d_strb_o(d_strb_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
        .start_i(start_i), .len_i(len_i), .shift_i(shift_i), .simple_mul_i(simple_mul_i),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o), .dbg_state_o(dbg_state_o)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (prev_stall) check("d_stable", {d_valid_o, d_data_o}, {1'b1, prev_data});
        prev_stall = d_valid_o && !d_ready_i && !rst_i;
        prev_data  = d_data_o;
        if (d_valid_o && d_ready_i) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_d: got 0x%0h with no expected value queued", d_data_o);
            end else begin
                e = exp_q.pop_front();
                check("d_data", d_data_o, e);
            end
        end
        if (c_ready_o) c_ready_cnt++;
        if (a_ready_o || b_ready_o) ab_ready_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [CW-1:0] len, input logic simple, input logic [4:0] sh);
        start_i      = 1'b1;
        len_i        = len;
        simple_mul_i = simple;
        shift_i      = sh;
        sync();
        start_i      = 1'b0;
    endtask

    task automatic feed(input int n, input logic use_c, input logic [31:0] cval);
        bit ok;
        for (int i = 0; i < n; i++) begin
            a_data_i  = va[i];
            b_data_i  = vb[i];
            c_data_i  = cval;
            a_valid_i = 1'b1;
            b_valid_i = 1'b1;
            c_valid_i = use_c && (i == 0);
            ok = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (a_ready_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                tests_run++;
                tests_failed++;
                $display("FAIL feed_timeout: pair %0d never accepted (ready=0, required 1)", i);
                break;
            end
            sync();
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        c_valid_i = 1'b0;
    endtask

    task automatic wait_done(input bit expect_hs);
        bit found, prev_hs;
        found   = 1'b0;
        prev_hs = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_o) begin
                found = 1'b1;
                if (expect_hs) check("done_after_hs", prev_hs, 1);
                check("busy_at_done", busy_o, 0);
                check("cnt_at_done", cnt_o, 0);
                break;
            end
            prev_hs = d_valid_o && d_ready_i;
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL done_timeout: done_o=0, required 1 within 60 cycles");
        end
        sync();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit stall_seen, done_seen;
        int ab0, c0;
        rst_i = 1'b1; enable_i = 1'b1; clear_i = 1'b0;
        a_data_i = '0; b_data_i = '0; c_data_i = '0;
        a_strb_i = 4'hF; b_strb_i = 4'hF; c_strb_i = 4'hF;
        a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0; d_ready_i = 1'b1;
        start_i = 1'b0; len_i = '0; shift_i = '0; simple_mul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check("rst_readies", {a_ready_o, b_ready_o, c_ready_o}, 0);
        check("rst_d_valid", d_valid_o, 0);
        check("rst_d_data", d_data_o, 0);
        check("rst_status", {busy_o, done_o, cnt_o}, 0);
        check("d_strb", d_strb_o, 4'hF);

        // accumulate len=4, seed 10
        c_ready_cnt = 0;
        exp_q.push_back(32'd80);
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb = '{32'd5, 32'd6, 32'd7, 32'd8};
        start_job(4, 1'b0, 5'd0);
        check("busy_after_start", busy_o, 1);
        feed(4, 1'b1, 32'd10);
        wait_done(1'b1);
        check("acc_c_ready_once", c_ready_cnt, 1);

        // simple mode with shift 16
        c_ready_cnt = 0;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0001_0000);
        exp_q.push_back(32'h0000_0000);
        va = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd7};
        vb = '{32'd4, 32'h0001_0000, 32'd2};
        start_job(3, 1'b1, 5'd16);
        feed(3, 1'b0, 32'd0);
        wait_done(1'b1);
        check("simple_c_ready_never", c_ready_cnt, 0);

        // simple mode with output backpressure
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd40);
        exp_q.push_back(32'd90);
        exp_q.push_back(32'd160);
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb = '{32'd10, 32'd20, 32'd30, 32'd40};
        d_ready_i = 1'b0;
        stall_seen = 1'b0;
        start_job(4, 1'b1, 5'd0);
        fork
            begin
                feed(4, 1'b0, 32'd0);
                check("cnt_full", cnt_o, 4);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (d_valid_o) break;
                end
                check("stall_d_valid", d_valid_o, 1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    stall_seen = stall_seen | a_ready_o | b_ready_o;
                end
                sync();
                d_ready_i = 1'b1;
            end
        join
        check("ready_drop_in_stall", stall_seen, 0);
        wait_done(1'b1);

        // zero-length job
        ab0 = ab_ready_cnt;
        c0  = c_ready_cnt;
        a_valid_i = 1'b1; b_valid_i = 1'b1; c_valid_i = 1'b1;
        start_job(0, 1'b0, 5'd0);
        check("len0_done", {done_o, busy_o}, 2'b10);
        sync();
        check("len0_done_pulse", {done_o, busy_o}, 2'b00);
        sync();
        check("len0_no_ready", (ab_ready_cnt - ab0) + (c_ready_cnt - c0), 0);
        a_valid_i = 1'b0; b_valid_i = 1'b0; c_valid_i = 1'b0;

        // reset mid-job, then a fresh job
        va = '{32'd1, 32'd2};
        vb = '{32'd3, 32'd4};
        start_job(4, 1'b0, 5'd0);
        feed(2, 1'b1, 32'd5);
        rst_i = 1'b1;
        sync();
        rst_i = 1'b0;
        check("abort_state", {busy_o, done_o, cnt_o, d_valid_o, d_data_o}, 0);
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            done_seen = done_seen | done_o;
        end
        check("abort_no_done", done_seen, 0);
        sync();
        exp_q.push_back(32'd12);
        va = '{32'd2, 32'd2};
        vb = '{32'd3, 32'd3};
        start_job(2, 1'b0, 5'd0);
        feed(2, 1'b1, 32'd0);
        wait_done(1'b1);

        // 64-bit accumulator wrap
        exp_q.push_back(32'd0);
        va = '{32'h8000_0000, 32'h8000_0000};
        vb = '{32'h8000_0000, 32'h8000_0000};
        start_job(2, 1'b0, 5'd31);
        feed(2, 1'b1, 32'd0);
        wait_done(1'b1);

        repeat (3) sync();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
